// File: rtl/adpll_cfg_pkg.sv
// Shared definitions for the ADPLL configuration controller: parameter
// indices, reset defaults and the commit FSM state type.
package adpll_cfg_pkg;

    localparam int PARAM_W = 5;

    localparam int IDX_KP       = 0;
    localparam int IDX_KI       = 1;
    localparam int IDX_DCO_INIT = 2;
    localparam int IDX_DIV_N    = 3;
    localparam int IDX_TDC_OFS  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } cfg_state_e;

    // Loop-parameter reset defaults; reserved slots (5..7) default to zero.
    function automatic logic [PARAM_W-1:0] param_default(input int idx);
        case (idx)
            IDX_KP:       return 5'd4;
            IDX_KI:       return 5'd1;
            IDX_DCO_INIT: return 5'd16;
            IDX_DIV_N:    return 5'd8;
            default:      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/adpll_cfg_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous pad pin; both stages are
// exposed so the parent can report activity anywhere in the chain.
module adpll_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s1,
    output logic s2
);

    logic s1_q, s2_q;

    // NOTE: flops use non-blocking assignments so that each stage samples
    // the previous stage's value from before the edge, not the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign s1 = s1_q;
    assign s2 = s2_q;

endmodule

// File: rtl/adpll_cfg_ctrl.sv
// ADPLL loop-parameter programming controller: shadow bank written from pins,
// committed to the live loop via upd_req/upd_ack. ADPLL_CFG_TIMEOUT_EN adds a
// forced commit after TIMEOUT cycles without ack and the sticky err flag.
module adpll_cfg_ctrl
    import adpll_cfg_pkg::*;
#(
    parameter int NPARAM  = 8,
    parameter int PW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pgm,
    input  logic              clr,
    input  logic [2:0]        param_sel,
    input  logic [PW-1:0]     pgm_value,
    input  logic              upd_ack,
    output logic              upd_req,
    output logic [NPARAM*PW-1:0] active,
    output logic [PW-1:0]     rd_data,
    output logic              busy,
    output logic              err
);

    logic pgm_s1, pgm_s2, clr_s1, clr_s2;
    logic pgm_s3_q, clr_s3_q;
    logic wr_stb, clr_stb;

    adpll_sync2 u_sync_pgm (.clk(clk), .rst_n(rst_n), .d(pgm), .s1(pgm_s1), .s2(pgm_s2));
    adpll_sync2 u_sync_clr (.clk(clk), .rst_n(rst_n), .d(clr), .s1(clr_s1), .s2(clr_s2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pgm_s3_q <= 1'b0;
            clr_s3_q <= 1'b0;
        end else begin
            pgm_s3_q <= pgm_s2;
            clr_s3_q <= clr_s2;
        end
    end

    assign wr_stb  = pgm_s2 & ~pgm_s3_q;
    assign clr_stb = clr_s2 & ~clr_s3_q;

    cfg_state_e          state_q;
    logic                upd_req_q;
    logic [NPARAM*PW-1:0] active_q;
    logic [NPARAM*PW-1:0] shadow_flat;
    logic [PW-1:0]       shadow_q [NPARAM];
    logic [PW-1:0]       shadow_d [NPARAM];
    logic                dirty_q, dirty_d;
    logic                tmo_hit;
    logic                commit;

`ifdef ADPLL_CFG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_q;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign commit = (state_q == ST_REQ) && (upd_ack || tmo_hit);

    // Clear takes priority over a simultaneous write; a commit in the same
    // cycle as either leaves dirty set so the new data gets its own commit.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        if (commit) begin
            dirty_d = 1'b0;
        end
        if (clr_stb) begin
            for (int i = 0; i < NPARAM; i++) begin
                shadow_d[i] = PW'(param_default(i));
            end
            dirty_d = 1'b1;
        end else if (wr_stb) begin
            shadow_d[param_sel] = pgm_value;
            dirty_d             = 1'b1;
        end
    end

    // NOTE: the shadow bank is reset to real defaults, not left undefined,
    // because rd_data and the first commit expose it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPARAM; i++) begin
                shadow_q[i] <= PW'(param_default(i));
            end
            dirty_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < NPARAM; i++) begin
            shadow_flat[i*PW +: PW] = shadow_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            upd_req_q <= 1'b0;
            for (int i = 0; i < NPARAM; i++) begin
                active_q[i*PW +: PW] <= PW'(param_default(i));
            end
`ifdef ADPLL_CFG_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dirty_q) begin
                        state_q   <= ST_REQ;
                        upd_req_q <= 1'b1;
`ifdef ADPLL_CFG_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (commit) begin
                        active_q  <= shadow_flat;
                        state_q   <= ST_IDLE;
                        upd_req_q <= 1'b0;
`ifdef ADPLL_CFG_TIMEOUT_EN
                        if (!upd_ack) begin
                            err_q <= 1'b1;
                        end
`endif
                    end
`ifdef ADPLL_CFG_TIMEOUT_EN
                    else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q   <= ST_IDLE;
                    upd_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign upd_req = upd_req_q;
    assign active  = active_q;
    assign rd_data = shadow_q[param_sel];
    assign busy    = pgm_s1 | pgm_s2 | pgm_s3_q | clr_s1 | clr_s2 | clr_s3_q
                   | dirty_q | (state_q == ST_REQ);

endmodule

// File: doc/adpll_cfg_ctrl.md
# adpll_cfg_ctrl

Programming and update controller for the ADPLL loop parameters. Captures pin-driven writes (`pgm`, `clr`, `param_sel`, `pgm_value`) into a shadow register bank. Commits the bank to the live loop only through a req/ack handshake at a datapath-chosen safe point, so the PI filter, DCO and divider never see a half-written configuration. Sits between the pad-level programming pins and `adpll_top`'s parameter inputs.

## Interface
Parameters:
- `NPARAM`, 8: number of 5-bit loop parameters (index = `param_sel`).
- `PW`, 5: parameter width.
- `TIMEOUT`, 255: cycles to wait for `upd_ack` before forced commit (only with macro).

Ports:
- `clk` in 1: sampling clock (50 MHz domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `pgm` in 1: asynchronous pin; rising edge writes one parameter.
- `clr` in 1: asynchronous pin; rising edge restores all shadow parameters to defaults.
- `param_sel` in 3: parameter index for write and readback.
- `pgm_value` in PW: write data.
- `upd_ack` in 1: one-cycle pulse from loop datapath at a safe update point.
- `upd_req` out 1: commit pending; held until ack (or timeout).
- `active` out NPARAM*PW: live parameters, param i at bits [i*PW +: PW].
- `rd_data` out PW: combinational readback of `shadow[param_sel]`.
- `busy` out 1: a write/clear is in synchronization or a commit is pending.
- `err` out 1: sticky; a forced (timeout) commit occurred.

## Operation
- `pgm` and `clr` each pass through a 2-flop synchronizer, then a registered edge detector (`s2 & ~s3`).
- `param_sel`/`pgm_value` sampled unsynchronized on the write cycle; they must be stable from ≥1 cycle before the `pgm` pin rises until its synchronized edge is consumed.
- Write: `shadow[param_sel] <= pgm_value`, set `dirty`.
- Clear: all `shadow` <= package defaults, set `dirty`. `active` unchanged until commit.
- Same-cycle clear and write edges: clear wins; the write is discarded.
- FSM:
  - IDLE: `dirty` -> REQ.
  - REQ: `upd_req`=1. On `upd_ack`, copy `shadow` to `active`, clear `dirty` -> IDLE.
  - REQ, timeout (macro only): forced copy, set `err` -> IDLE.
- Write or clear in the same cycle as `upd_ack`:
  - Copy uses pre-write shadow.
  - `dirty` stays set; FSM returns to IDLE, then REQ again next cycle.
- `upd_ack` outside REQ is ignored.
- `busy` = any sync stage or edge register high, or `dirty`, or state REQ.
- Reset, including mid-commit: `shadow` = `active` = defaults, `dirty`=0, state IDLE, `upd_req`=0, `busy`=0, `err`=0, sync flops 0. `rd_data` = default of current `param_sel`.

## Timing
- Pin rise sampled at edge k: shadow written at edge k+2; `upd_req` high after edge k+3.
- Ack at edge m: `active` valid after edge m; `upd_req` low after edge m.
- Minimum pin-to-active latency: 5 cycles with immediate ack.
- Back-to-back writes: `pgm` pin must stay low ≥2 cycles between pulses. Shorter gaps may merge; this is not an error.
- Timeout counter starts at REQ entry. Forced commit occurs on the `TIMEOUT`-th cycle without ack.

## Configuration
- `ADPLL_CFG_TIMEOUT_EN` defined: timeout counter, forced commit, `err` set.
- Undefined: REQ waits indefinitely, no counter logic, `err` tied 0.

## Structure
- `adpll_cfg_pkg`:
  - parameter index constants: KP=0, KI=1, DCO_INIT=2, DIV_N=3, TDC_OFS=4, 5–7 reserved.
  - reset defaults: KP=4, KI=1, DCO_INIT=16, DIV_N=8, others 0.
  - FSM state typedef (IDLE, REQ).
- Sub-module `adpll_sync2` (2-flop synchronizer, async active-low reset), instantiated for `pgm` and `clr`.

## Test plan
- Reset release -> `active` = {KP=4,KI=1,DCO_INIT=16,DIV_N=8,0…}, `upd_req`=0, `err`=0.
- Write sel=3, value=12; ack 2 cycles after `upd_req` -> `active[DIV_N]`=12 exactly at ack edge, `upd_req` drops, `rd_data`=12.
- Write sel=0 value=7 landing on the ack cycle of a prior commit -> first commit excludes 7, second `upd_req` follows, final KP=7.
- `clr` and `pgm` edges in the same cycle (sel=1, value=9) -> KI shadow=1, not 9, after commit.
- Macro on, TIMEOUT=255, no ack -> forced commit on cycle 255 after REQ entry, `err`=1 and sticky until reset. Macro off -> `upd_req` held, `active` unchanged.
- `rst_n` low while `upd_req`=1 -> outputs return to reset values asynchronously; the pending write is lost.
